// File: rtl/ms_timer_sched_if.sv
// ms_timer_sched_if: requester-side bus of the millisecond timer scheduler.
// Carries the per-channel load handshake, cancel pulses and status outputs.
// The master modport is the requester side and the slave modport is the scheduler side.
interface ms_timer_sched_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  logic [NUM_CH-1:0]       req;
  logic [NUM_CH*CNT_W-1:0] req_ms;
  logic [NUM_CH-1:0]       req_periodic;
  logic [NUM_CH-1:0]       cancel;
  logic [NUM_CH-1:0]       ack;
  logic [NUM_CH-1:0]       expire;
  logic [NUM_CH-1:0]       busy;

  modport master (
    output req, req_ms, req_periodic, cancel,
    input  ack, expire, busy
  );

  modport slave (
    input  req, req_ms, req_periodic, cancel,
    output ack, expire, busy
  );
endinterface

// File: rtl/ms_timer_sched.sv
// ms_timer_sched: multi-channel millisecond timer scheduler.
// Each channel is loaded through a round-robin req/ack handshake. It then counts
// ms_tick pulses and raises a one-cycle expire pulse when its delay has elapsed.
// A periodic channel re-arms itself when it expires.
// Optional feature macro: MS_SCHED_AUTOGATE_EN. When it is defined, ms_en is a
// register that stops the ms counter while every channel is idle. When it is
// undefined, ms_en is tied high.
module ms_timer_sched #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ms_tick,
  output logic ms_en,
  ms_timer_sched_if.slave bus
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  ch_state_t         state_q     [NUM_CH];
  ch_state_t         state_d     [NUM_CH];
  logic [CNT_W-1:0]  remaining_q [NUM_CH];
  logic [CNT_W-1:0]  remaining_d [NUM_CH];
  logic [CNT_W-1:0]  period_q    [NUM_CH];
  logic [CNT_W-1:0]  period_d    [NUM_CH];
  logic [NUM_CH-1:0] periodic_q, periodic_d;
  logic [NUM_CH-1:0] expire_q, expire_d;
  logic [NUM_CH-1:0] busy_q, busy_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic              grant_vld;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  cand;
  logic [NUM_CH-1:0] grant_vec;

  // Channel index arithmetic modulo NUM_CH, used by the round-robin search.
  function automatic int wrap_idx(input int base, input int off);
    return (base + off) % NUM_CH;
  endfunction

  assign bus.ack    = grant_vec;
  assign bus.expire = expire_q;
  assign bus.busy   = busy_q;

  // Round-robin grant: the first requester from rr_ptr onward that is not cancelling.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    grant_vec = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = PTR_W'(wrap_idx(int'(rr_ptr_q), k));
      if (!grant_vld && bus.req[cand] && !bus.cancel[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end else begin
        grant_vld = grant_vld;
      end
    end
    if (grant_vld) begin
      grant_vec[grant_idx] = 1'b1;
      rr_ptr_d = PTR_W'(wrap_idx(int'(grant_idx), 1));
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Per-channel next state. Priority order is cancel, then load, then tick countdown.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]     = state_q[i];
      remaining_d[i] = remaining_q[i];
      period_d[i]    = period_q[i];
      periodic_d[i]  = periodic_q[i];
      expire_d[i]    = 1'b0;
      busy_d[i]      = 1'b0;
      if (bus.cancel[i]) begin
        state_d[i] = IDLE;
      end else if (grant_vec[i]) begin
        remaining_d[i] = bus.req_ms[i*CNT_W +: CNT_W];
        period_d[i]    = bus.req_ms[i*CNT_W +: CNT_W];
        if (bus.req_ms[i*CNT_W +: CNT_W] == CNT_ZERO) begin
          // A zero delay times out immediately and never arms the channel.
          state_d[i]    = IDLE;
          periodic_d[i] = 1'b0;
          expire_d[i]   = 1'b1;
        end else begin
          state_d[i]    = RUN;
          periodic_d[i] = bus.req_periodic[i];
        end
      end else if (ms_tick) begin
        case (state_q[i])
          RUN: begin
            if (remaining_q[i] > CNT_ONE) begin
              remaining_d[i] = remaining_q[i] - CNT_ONE;
            end else begin
              expire_d[i] = 1'b1;
              if (periodic_q[i]) begin
                remaining_d[i] = period_q[i];
              end else begin
                // A one-shot channel keeps busy high through its expire cycle.
                state_d[i] = IDLE;
                busy_d[i]  = 1'b1;
              end
            end
          end
          IDLE: begin
            state_d[i] = IDLE;
          end
          default: begin
            state_d[i] = IDLE;
          end
        endcase
      end else begin
        state_d[i] = state_q[i];
      end
      busy_d[i] = busy_d[i] | (state_d[i] == RUN);
    end
  end

  // Registered channel state, round-robin pointer and the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]     <= IDLE;
        remaining_q[i] <= '0;
        period_q[i]    <= '0;
      end
      periodic_q <= '0;
      expire_q   <= '0;
      busy_q     <= '0;
      rr_ptr_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]     <= state_d[i];
        remaining_q[i] <= remaining_d[i];
        period_q[i]    <= period_d[i];
      end
      periodic_q <= periodic_d;
      expire_q   <= expire_d;
      busy_q     <= busy_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

`ifdef MS_SCHED_AUTOGATE_EN
  logic any_run;

  // Detect whether any channel is currently armed.
  always_comb begin
    any_run = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      any_run = any_run | (state_q[i] == RUN);
    end
  end

  // Keep the ms counter running while a channel is armed or is being loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ms_en <= 1'b0;
    end else begin
      ms_en <= any_run | grant_vld;
    end
  end
`else
  assign ms_en = 1'b1;
`endif

endmodule

// File: tb/tb_ms_timer_sched.sv
// tb_ms_timer_sched: self-checking bench for ms_timer_sched.
// The bench first applies an arbitration vector table, then hand-written corner
// sequences. It then runs randomized traffic against a tick-counting reference model.
module tb_ms_timer_sched;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst;
  logic ms_tick;
  logic ms_en;
  int   checks   = 0;
  int   failures = 0;

`ifdef MS_SCHED_AUTOGATE_EN
  localparam logic EN_RST = 1'b0;
`else
  localparam logic EN_RST = 1'b1;
`endif

  always #5 clk = ~clk;

  ms_timer_sched_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  ms_timer_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ms_tick(ms_tick), .ms_en(ms_en), .bus(bus)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] cancel;
    logic [3:0] exp_ack;
  } arb_vec_t;

  arb_vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_ms(input int ch, input logic [CNT_W-1:0] v);
    bus.req_ms[ch*CNT_W +: CNT_W] = v;
  endtask

  task automatic idle_inputs();
    bus.req          = '0;
    bus.cancel       = '0;
    bus.req_periodic = '0;
    bus.req_ms       = '0;
    ms_tick          = 1'b0;
  endtask

  // Reset the DUT and return at a negedge with inputs idle.
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model state: ticks seen since the load, compared against the delay.
  bit          armed [NUM_CH];
  bit          per_m [NUM_CH];
  int          n_m   [NUM_CH];
  int          seen  [NUM_CH];
  int          mptr;
  logic [3:0]  m_exp, m_busy, m_ack;
  bit          rq    [NUM_CH];
  int          ms_v  [NUM_CH];
  bit          pr_v  [NUM_CH];

  initial begin
    int exp_cnt;
    tbl[0]  = '{4'b1111, 4'b0000, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0000, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0000, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b0000, 4'b1000};
    tbl[4]  = '{4'b1010, 4'b0000, 4'b0010};
    tbl[5]  = '{4'b1010, 4'b0000, 4'b1000};
    tbl[6]  = '{4'b0010, 4'b0010, 4'b0000};
    tbl[7]  = '{4'b0011, 4'b0001, 4'b0010};
    tbl[8]  = '{4'b0000, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b0101, 4'b0000, 4'b0100};
    tbl[10] = '{4'b0101, 4'b0000, 4'b0001};

    // Reset state
    do_reset();
    chk("rst_ack", bus.ack, 4'b0000);
    chk("rst_expire", bus.expire, 4'b0000);
    chk("rst_busy", bus.busy, 4'b0000);
    chk("rst_ms_en", ms_en, EN_RST);

    // Arbitration table (long delays so nothing expires)
    for (int c = 0; c < NUM_CH; c++) set_ms(c, 16'd100);
    for (int v = 0; v < 11; v++) begin
      bus.req    = tbl[v].req;
      bus.cancel = tbl[v].cancel;
      #1 chk("arb_ack", bus.ack, tbl[v].exp_ack);
      @(negedge clk);
    end

    // One-shot: N=3, ticks at t+5, t+10, t+15
    do_reset();
    bus.req[0] = 1'b1;
    set_ms(0, 16'd3);
    #1 chk("oneshot_ack", bus.ack, 4'b0001);
    @(negedge clk);
    bus.req = '0;
    for (int c = 1; c <= 18; c++) begin
      chk("oneshot_expire", bus.expire[0], (c == 16));
      chk("oneshot_busy", bus.busy[0], (c <= 16));
      ms_tick = (c == 5 || c == 10 || c == 15);
      @(negedge clk);
    end
    ms_tick = 1'b0;

    // Periodic: ch2 N=2, 8 ticks spaced 3 cycles apart
    do_reset();
    bus.req[2] = 1'b1;
    bus.req_periodic[2] = 1'b1;
    set_ms(2, 16'd2);
    #1 chk("per_ack", bus.ack, 4'b0100);
    @(negedge clk);
    bus.req = '0;
    exp_cnt = 0;
    for (int c = 1; c <= 27; c++) begin
      chk("per_expire", bus.expire[2], (c > 1 && (c - 1) % 6 == 0 && c <= 25));
      chk("per_busy", bus.busy[2], 1'b1);
      if (bus.expire[2]) exp_cnt++;
      ms_tick = (c % 3 == 0 && c <= 24);
      @(negedge clk);
    end
    chk("per_expire_count", exp_cnt, 4);
    bus.cancel[2] = 1'b1;
    @(negedge clk);
    bus.cancel = '0;
    for (int c = 0; c < 8; c++) begin
      chk("per_cancel_busy", bus.busy[2], 1'b0);
      chk("per_cancel_expire", bus.expire[2], 1'b0);
      ms_tick = 1'b1;
      @(negedge clk);
    end
    ms_tick = 1'b0;

    // Cancel on the timeout cycle suppresses expire
    do_reset();
    bus.req[1] = 1'b1;
    set_ms(1, 16'd2);
    #1 chk("coll_ack", bus.ack, 4'b0010);
    @(negedge clk);
    bus.req = '0;
    ms_tick = 1'b1;
    @(negedge clk);
    ms_tick = 1'b0;
    @(negedge clk);
    ms_tick = 1'b1;
    bus.cancel[1] = 1'b1;
    @(negedge clk);
    ms_tick = 1'b0;
    bus.cancel = '0;
    for (int c = 0; c < 4; c++) begin
      chk("coll_cancel_expire", bus.expire[1], 1'b0);
      chk("coll_cancel_busy", bus.busy[1], 1'b0);
      @(negedge clk);
    end

    // req and cancel together: no ack
    bus.req[1] = 1'b1;
    bus.cancel[1] = 1'b1;
    #1 chk("coll_req_cancel_ack", bus.ack, 4'b0000);
    @(negedge clk);
    bus.req = '0;
    bus.cancel = '0;
    chk("coll_req_cancel_busy", bus.busy[1], 1'b0);

    // Reload on a tick cycle: the tick is ignored
    bus.req[1] = 1'b1;
    set_ms(1, 16'd3);
    #1 chk("reload_ack1", bus.ack, 4'b0010);
    @(negedge clk);
    bus.req = '0;
    ms_tick = 1'b1;
    @(negedge clk);
    ms_tick = 1'b0;
    @(negedge clk);
    bus.req[1] = 1'b1;
    set_ms(1, 16'd5);
    ms_tick = 1'b1;
    #1 chk("reload_ack2", bus.ack, 4'b0010);
    @(negedge clk);
    bus.req = '0;
    for (int c = 1; c <= 12; c++) begin
      chk("reload_expire", bus.expire[1], (c == 10));
      chk("reload_busy", bus.busy[1], (c <= 10));
      ms_tick = (c % 2 == 1 && c <= 9);
      @(negedge clk);
    end
    ms_tick = 1'b0;

    // req_ms=0 on ch3
    bus.req[3] = 1'b1;
    bus.req_periodic[3] = 1'b1;
    set_ms(3, 16'd0);
    #1 chk("zero_ack", bus.ack, 4'b1000);
    @(negedge clk);
    bus.req = '0;
    bus.req_periodic = '0;
    chk("zero_expire", bus.expire[3], 1'b1);
    chk("zero_busy", bus.busy[3], 1'b0);
    @(negedge clk);
    chk("zero_expire_after", bus.expire[3], 1'b0);
    chk("zero_busy_after", bus.busy[3], 1'b0);

    // Async reset mid-countdown
    bus.req[2] = 1'b1;
    bus.req_periodic[2] = 1'b1;
    set_ms(2, 16'd1);
    @(negedge clk);
    bus.req = '0;
    ms_tick = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_pre_expire", bus.expire[2], 1'b1);
    chk("arst_pre_busy", bus.busy[2], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_expire", bus.expire, 4'b0000);
    chk("arst_busy", bus.busy, 4'b0000);
    chk("arst_ack", bus.ack, 4'b0000);
    chk("arst_ms_en", ms_en, EN_RST);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      armed[i] = 1'b0; per_m[i] = 1'b0; n_m[i] = 0; seen[i] = 0;
      rq[i] = 1'b0; ms_v[i] = 0; pr_v[i] = 1'b0;
    end
    mptr = 0;
    m_exp = '0;
    m_busy = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int g;
      logic tick;
      chk("rand_expire", bus.expire, m_exp);
      chk("rand_busy", bus.busy, m_busy);
      tick = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        if (!rq[i]) begin
          if ($urandom_range(0, 7) == 0) begin
            rq[i] = 1'b1;
            ms_v[i] = $urandom_range(0, 5);
            pr_v[i] = 1'($urandom_range(0, 1));
          end
        end else if ($urandom_range(0, 29) == 0) begin
          rq[i] = 1'b0;
        end
        bus.req[i] = rq[i];
        bus.req_periodic[i] = pr_v[i];
        set_ms(i, CNT_W'(ms_v[i]));
        bus.cancel[i] = ($urandom_range(0, 19) == 0);
      end
      ms_tick = tick;
      // Expected grant: first requester from the pointer that is not cancelling
      g = -1;
      for (int k = 0; k < NUM_CH; k++) begin
        int idx;
        idx = (mptr + k) % NUM_CH;
        if (g < 0 && rq[idx] && !bus.cancel[idx]) g = idx;
      end
      m_ack = '0;
      if (g >= 0) m_ack[g] = 1'b1;
      #1 chk("rand_ack", bus.ack, m_ack);
      // Model update for the next cycle
      for (int i = 0; i < NUM_CH; i++) begin
        bit was_armed;
        was_armed = armed[i];
        m_exp[i] = 1'b0;
        m_busy[i] = 1'b0;
        if (bus.cancel[i]) begin
          armed[i] = 1'b0;
        end else if (g == i) begin
          if (ms_v[i] == 0) begin
            armed[i] = 1'b0;
            m_exp[i] = 1'b1;
          end else begin
            armed[i] = 1'b1;
            n_m[i] = ms_v[i];
            per_m[i] = pr_v[i];
            seen[i] = 0;
          end
        end else if (was_armed && tick) begin
          seen[i]++;
          if (seen[i] % n_m[i] == 0) begin
            m_exp[i] = 1'b1;
            if (!per_m[i]) begin
              armed[i] = 1'b0;
              m_busy[i] = 1'b1;
            end
          end
        end
        m_busy[i] = m_busy[i] | armed[i];
      end
      if (g >= 0) begin
        mptr = (g + 1) % NUM_CH;
        rq[g] = 1'b0;
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
